// File: rtl/fp16_mul_pkg.sv
// Shared constants and types for the FP16 multiplier exponent path.
package fp16_mul_pkg;

  localparam int EXP_W        = 6;
  localparam int FP16_EXP_W   = 5;
  localparam int DEFAULT_BIAS = 15;
  localparam int EXP_INF      = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_SUB  = 2'd2,
    ST_RESP = 2'd3
  } exp_sched_state_t;

endpackage

// File: rtl/exp_addsub6.sv
// Combinational 6-bit ripple add/sub; op=1 computes a - b as a + ~b + 1.
module exp_addsub6 (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       op,
  output logic [5:0] y,
  output logic       cout
);

  logic [5:0] b_eff;
  logic       carry;

  assign b_eff = b ^ {6{op}};

  // NOTE: every variable written here gets a value before use on all paths, so no latch is inferred.
  always_comb begin
    carry = op;
    y     = '0;
    for (int i = 0; i < 6; i++) begin
      y[i]  = a[i] ^ b_eff[i] ^ carry;
      carry = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/fp16_exp_sched.sv
// Round-robin scheduler sharing one exponent add/sub unit among N_REQ multiplier lanes.
module fp16_exp_sched
  import fp16_mul_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BIAS  = DEFAULT_BIAS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*5-1:0]         req_exp_a,
  input  logic [N_REQ*5-1:0]         req_exp_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [5:0]                 rsp_exp,
  output logic                       rsp_ovf,
  output logic                       rsp_unf
);

  localparam int ID_W = $clog2(N_REQ);

  exp_sched_state_t state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  id_q;
  logic [EXP_W-1:0] a_q, b_q, sum_q;

  logic             grant_found, grant_valid;
  logic [ID_W-1:0]  grant_id;
  logic [FP16_EXP_W-1:0] sel_a, sel_b;

  logic [EXP_W-1:0] unit_a, unit_b, unit_y;
  logic             unit_op, unit_cout;
  logic             sub_unf, sub_ovf;

  // First requesting lane at or above the pointer, wrapping upward.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_found && req_valid[(int'(ptr_q) + k) % N_REQ]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign grant_valid = rst_n && (state_q == ST_IDLE) && grant_found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++)
      req_ready[i] = grant_valid && (grant_id == ID_W'(i));
  end

  assign sel_a = req_exp_a[int'(grant_id)*FP16_EXP_W +: FP16_EXP_W];
  assign sel_b = req_exp_b[int'(grant_id)*FP16_EXP_W +: FP16_EXP_W];

  // The shared unit sees operands only in ADD and SUB; otherwise it idles at zero.
  always_comb begin
    unit_a  = '0;
    unit_b  = '0;
    unit_op = 1'b0;
    case (state_q)
      ST_ADD: begin
        unit_a = a_q;
        unit_b = b_q;
      end
      ST_SUB: begin
        unit_a  = sum_q;
        unit_b  = EXP_W'(BIAS);
        unit_op = 1'b1;
      end
      default: ;
    endcase
  end

  exp_addsub6 u_addsub (
    .a    (unit_a),
    .b    (unit_b),
    .op   (unit_op),
    .y    (unit_y),
    .cout (unit_cout)
  );

  // No carry-out means a borrow: sum was below the bias.
  assign sub_unf = !unit_cout || (unit_y == '0);
  assign sub_ovf = !sub_unf && (unit_y >= EXP_W'(EXP_INF));

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, including operand and datapath holding regs, is reset so an aborted transaction leaves nothing behind.
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_exp   <= '0;
      rsp_ovf   <= 1'b0;
      rsp_unf   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            a_q     <= {1'b0, sel_a};
            b_q     <= {1'b0, sel_b};
            id_q    <= grant_id;
            ptr_q   <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            state_q <= ST_ADD;
          end
        end
        ST_ADD: begin
          sum_q   <= unit_y;
          state_q <= ST_SUB;
        end
        ST_SUB: begin
          rsp_exp   <= sub_unf ? '0 : unit_y;
          rsp_ovf   <= sub_ovf;
          rsp_unf   <= sub_unf;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_exp_sched.sv
// Self-checking bench for fp16_exp_sched: vector table, random traffic, and multi-cycle corner sequences.
module tb_fp16_exp_sched;

  localparam int N    = 4;
  localparam int BIAS = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid, req_ready;
  logic [N*5-1:0] req_exp_a, req_exp_b;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [5:0]   rsp_exp;
  logic         rsp_ovf, rsp_unf;

  int total = 0;
  int bad   = 0;

  fp16_exp_sched #(.N_REQ(N), .BIAS(BIAS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_exp_a (req_exp_a),
    .req_exp_b (req_exp_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_exp   (rsp_exp),
    .rsp_ovf   (rsp_ovf),
    .rsp_unf   (rsp_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lane;
    int a;
    int b;
    int e;
    int ovf;
    int unf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input int a, input int b);
    logic [4:0] a5, b5;
    a5 = 5'(a);
    b5 = 5'(b);
    req_exp_a[lane*5 +: 5] = a5;
    req_exp_b[lane*5 +: 5] = b5;
  endtask

  // Reference: exponent of the product is a + b - bias, classified by range.
  task automatic model(input int a, input int b, output int e, output int ovf, output int unf);
    int r;
    r   = a + b - BIAS;
    unf = (r <= 0) ? 1 : 0;
    ovf = (r >= 31) ? 1 : 0;
    e   = unf ? 0 : r;
  endtask

  task automatic wait_grant(input string tag, output bit ok);
    int waited;
    waited = 0;
    while (req_ready == '0 && waited < 20) begin
      step();
      waited++;
    end
    ok = (req_ready != '0);
    if (!ok) check({tag, " grant timeout"}, 0, 1);
  endtask

  task automatic run_txn(input int lane, input int a, input int b,
                         input int e, input int ovf, input int unf, input string tag);
    bit ok;
    req_valid       = '0;
    req_valid[lane] = 1'b1;
    set_lane(lane, a, b);
    rsp_ready = 1'b1;
    #1;
    wait_grant(tag, ok);
    if (!ok) return;
    check({tag, " grant"}, 32'(req_ready), 32'(1 << lane));
    step();
    check({tag, " ready in add"}, 32'(req_ready), 0);
    req_valid = '0;
    check({tag, " valid t+1"}, 32'(rsp_valid), 0);
    step();
    check({tag, " valid t+2"}, 32'(rsp_valid), 0);
    step();
    check({tag, " valid t+3"}, 32'(rsp_valid), 1);
    check({tag, " id"},  32'(rsp_id),  32'(lane));
    check({tag, " exp"}, 32'(rsp_exp), 32'(e));
    check({tag, " ovf"}, 32'(rsp_ovf), 32'(ovf));
    check({tag, " unf"}, 32'(rsp_unf), 32'(unf));
    step();
    check({tag, " valid t+4"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[12];
    int   gl[5], gc[5];
    int   ng, pend, e, o, u, ln, a, b;
    bit   ok, seen;
    int   exp_order[5];

    vecs[0]  = '{0, 15, 15, 15, 0, 0};
    vecs[1]  = '{1, 30, 20, 35, 1, 0};
    vecs[2]  = '{1, 30, 30, 45, 1, 0};
    vecs[3]  = '{2,  3,  5,  0, 0, 1};
    vecs[4]  = '{2, 10,  5,  0, 0, 1};
    vecs[5]  = '{3, 31, 31, 47, 1, 0};
    vecs[6]  = '{0,  0,  0,  0, 0, 1};
    vecs[7]  = '{3,  8,  8,  1, 0, 0};
    vecs[8]  = '{1, 23, 23, 31, 1, 0};
    vecs[9]  = '{2, 22, 23, 30, 0, 0};
    vecs[10] = '{0, 15, 31, 31, 1, 0};
    vecs[11] = '{3,  7,  8,  0, 0, 1};
    exp_order = '{0, 1, 2, 3, 0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_exp_a = '0;
    req_exp_b = '0;
    rsp_ready = 1'b0;
    step();
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset rsp_id",    32'(rsp_id),    0);
    check("reset rsp_exp",   32'(rsp_exp),   0);
    check("reset rsp_ovf",   32'(rsp_ovf),   0);
    check("reset rsp_unf",   32'(rsp_unf),   0);
    check("reset req_ready", 32'(req_ready), 0);

    // Round-robin from reset: every lane valid, lane 0 keeps re-requesting.
    req_valid = '1;
    for (int i = 0; i < N; i++) set_lane(i, 16, 16);
    rsp_ready = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
    ng   = 0;
    pend = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (req_ready != '0) begin
        check("rr onehot", 32'($countones(req_ready)), 1);
        ln = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) ln = i;
        if (ng < 5) begin
          gl[ng] = ln;
          gc[ng] = cyc;
        end
        ng++;
        pend = ln;
      end
      step();
      if (pend >= 0) begin
        check("rr one cycle wide", 32'(req_ready), 0);
        if (pend != 0) req_valid[pend] = 1'b0;
        pend = -1;
      end
    end
    req_valid = '0;
    check("rr grant count", 32'(ng), 5);
    if (ng >= 5) begin
      for (int k = 0; k < 5; k++) begin
        check("rr lane order", 32'(gl[k]), 32'(exp_order[k]));
        check("rr grant spacing", 32'(gc[k] - gc[0]), 32'(4 * k));
      end
    end
    step();
    step();

    for (int i = 0; i < 12; i++)
      run_txn(vecs[i].lane, vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].ovf, vecs[i].unf, "vec");

    for (int i = 0; i < 30; i++) begin
      ln = int'($urandom_range(0, N - 1));
      a  = int'($urandom_range(0, 31));
      b  = int'($urandom_range(0, 31));
      model(a, b, e, o, u);
      run_txn(ln, a, b, e, o, u, "rand");
    end

    // Backpressure: response held while other lanes wait.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    set_lane(1, 20, 20);
    set_lane(0, 16, 16);
    set_lane(2, 16, 16);
    #1;
    wait_grant("bp", ok);
    if (ok) begin
      step();
      req_valid = 4'b0101;
      step();
      step();
      for (int i = 0; i < 5; i++) begin
        check("bp rsp_valid", 32'(rsp_valid), 1);
        check("bp rsp_exp",   32'(rsp_exp),   25);
        check("bp rsp_id",    32'(rsp_id),    1);
        check("bp no ready",  32'(req_ready), 0);
        step();
      end
      rsp_ready = 1'b1;
      #1;
      check("bp accept no ready", 32'(req_ready), 0);
      check("bp accept valid",    32'(rsp_valid), 1);
      step();
      check("bp next grant", 32'(req_ready), 32'(4'b0100));
      check("bp valid drop", 32'(rsp_valid), 0);
      step();
      req_valid = '0;
      step();
      step();
      check("bp second id",  32'(rsp_id),  2);
      check("bp second exp", 32'(rsp_exp), 17);
      step();
    end

    // Reset in the middle of a lane-3 transaction.
    req_valid = 4'b1000;
    set_lane(3, 20, 20);
    rsp_ready = 1'b1;
    #1;
    wait_grant("rst", ok);
    if (ok) begin
      step();
      req_valid = '0;
      step();
      #2;
      req_valid = 4'b1000;
      rst_n     = 1'b0;
      #1;
      check("rst rsp_valid", 32'(rsp_valid), 0);
      check("rst rsp_id",    32'(rsp_id),    0);
      check("rst rsp_exp",   32'(rsp_exp),   0);
      check("rst rsp_ovf",   32'(rsp_ovf),   0);
      check("rst rsp_unf",   32'(rsp_unf),   0);
      check("rst req_ready", 32'(req_ready), 0);
      step();
      req_valid = '0;
      rst_n     = 1'b1;
      seen      = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (rsp_valid) seen = 1'b1;
        step();
      end
      check("rst no stale response", 32'(seen), 0);
      run_txn(2, 20, 20, 25, 0, 0, "post rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
